pbus_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares the single peripheral bus (addr/wdata/wstrb/valid/we, rdata/ready) between NUM_REQ requesters, e.g. the core data path and the debug module.
- Registers the winning request and drives it onto the pbus until the peripheral signals ready.
- Returns read data plus a one-hot response strobe to the owning requester.
- Optionally terminates hung transfers with an error after a watchdog timeout.
- Sits between the requesters and the Wishbone-to-pbus slave bridge / peripheral mux.

---
 rtl/pbus_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_pbus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbus_arbiter.sv
// pbus_arbiter
//   Round-robin arbiter and transaction sequencer that shares one peripheral
//   bus (pbus) between NUM_REQ requesters. The winning request is registered
//   and held on the pbus until the peripheral signals ready. The read data and
//   a one-hot response strobe are then returned to the owning requester.
//
//   Each transfer walks IDLE -> BUSY -> RESP -> IDLE.
//   Handshake: a requester holds req_valid_i[i] and its fields stable until it
//   sees rsp_valid_o[i] for exactly one cycle. It may then drop the request or
//   present a new one from the following cycle on. On the pbus side, the
//   transfer is active while pbus_valid_o is high. It completes in the first
//   cycle where pbus_ready_i is also high.
//
//   Optional feature macro: PBUS_ARB_TIMEOUT_EN. When it is defined, a watchdog
//   ends a BUSY transfer after TIMEOUT_CYC cycles without ready. The response
//   is rsp_err_o = 1 and rsp_rdata_o = 0. When it is undefined, BUSY waits
//   indefinitely for ready and rsp_err_o is tied to 0.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   req_valid_i      per-requester request
//   req_addr_i       packed addresses, requester i at [32i+31:32i]
//   req_wdata_i      packed write data, requester i at [32i+31:32i]
//   req_wstrb_i      packed byte strobes, requester i at [4i+3:4i]
//   req_we_i         per-requester write enable
//   rsp_valid_o      one-hot, one-cycle response strobe
//   rsp_rdata_o      read data, qualified by rsp_valid_o
//   rsp_err_o        error flag, qualified by rsp_valid_o
//   pbus_addr_o      registered pbus address
//   pbus_wdata_o     registered pbus write data
//   pbus_wstrb_o     registered pbus byte strobes (0 for reads)
//   pbus_valid_o     pbus transfer active
//   pbus_we_o        registered pbus write enable
//   pbus_rdata_i     peripheral read data
//   pbus_ready_i     peripheral completes the transfer this cycle
module pbus_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [NUM_REQ*32-1:0] req_addr_i,
    input  logic [NUM_REQ*32-1:0] req_wdata_i,
    input  logic [NUM_REQ*4-1:0]  req_wstrb_i,
    input  logic [NUM_REQ-1:0]    req_we_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [31:0]           pbus_addr_o,
    output logic [31:0]           pbus_wdata_o,
    output logic [3:0]            pbus_wstrb_o,
    output logic                  pbus_valid_o,
    output logic                  pbus_we_o,
    input  logic [31:0]           pbus_rdata_i,
    input  logic                  pbus_ready_i
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("pbus_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                we_q, we_d;
    logic                pvalid_q, pvalid_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;

`ifdef PBUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    // Round-robin pick. First look for the lowest requester above last_grant.
    // If there is none, wrap around and take the lowest requester overall.
    int          hi_idx;
    int          lo_idx;
    int          pick_idx;
    logic        hi_found;
    logic        any_req;
    logic [31:0] pick_addr;
    logic [31:0] pick_wdata;
    logic [3:0]  pick_wstrb;
    logic        pick_we;

    always_comb begin
        hi_idx     = 0;
        lo_idx     = 0;
        hi_found   = 1'b0;
        any_req    = |req_valid_i;
        pick_addr  = '0;
        pick_wdata = '0;
        pick_wstrb = '0;
        pick_we    = 1'b0;
        // Scan from the top down so the lowest qualifying index wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                lo_idx = i;
                if (i > int'(last_grant_q)) begin
                    hi_idx   = i;
                    hi_found = 1'b1;
                end
            end
        end
        pick_idx = hi_found ? hi_idx : lo_idx;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == pick_idx) begin
                pick_addr  = req_addr_i[i*32 +: 32];
                pick_wdata = req_wdata_i[i*32 +: 32];
                pick_wstrb = req_wstrb_i[i*4 +: 4];
                pick_we    = req_we_i[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        we_d         = we_q;
        pvalid_d     = pvalid_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
`ifdef PBUS_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    last_grant_d = GW'(pick_idx);
                    addr_d       = pick_addr;
                    wdata_d      = pick_wdata;
                    // Reads never present byte strobes on the pbus.
                    wstrb_d      = pick_we ? pick_wstrb : 4'b0000;
                    we_d         = pick_we;
                    pvalid_d     = 1'b1;
                    state_d      = BUSY;
`ifdef PBUS_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            BUSY: begin
                // last_grant_q holds the owner of the transfer in flight.
                if (pbus_ready_i) begin
                    rsp_rdata_d               = pbus_rdata_i;
                    rsp_valid_d[last_grant_q] = 1'b1;
                    pvalid_d                  = 1'b0;
                    state_d                   = RESP;
`ifdef PBUS_ARB_TIMEOUT_EN
                    err_d                     = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    // Final BUSY cycle without ready: terminate with an error.
                    rsp_rdata_d               = 32'h0;
                    err_d                     = 1'b1;
                    rsp_valid_d[last_grant_q] = 1'b1;
                    pvalid_d                  = 1'b0;
                    state_d                   = RESP;
                end else begin
                    cnt_d                     = cnt_q + CW'(1);
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                pvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            we_q         <= 1'b0;
            pvalid_q     <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
`ifdef PBUS_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            we_q         <= we_d;
            pvalid_q     <= pvalid_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
`ifdef PBUS_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign pbus_addr_o  = addr_q;
    assign pbus_wdata_o = wdata_q;
    assign pbus_wstrb_o = wstrb_q;
    assign pbus_we_o    = we_q;
    assign pbus_valid_o = pvalid_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
`ifdef PBUS_ARB_TIMEOUT_EN
    assign rsp_err_o    = err_q;
`else
    assign rsp_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_pbus_arbiter.sv
// tb_pbus_arbiter
//   Directed bench for pbus_arbiter with NUM_REQ = 2 and TIMEOUT_CYC = 8.
//   A peripheral model answers pbus transfers after a programmable number of
//   wait states. It returns data from rdata_of(addr) and toggles ready randomly
//   outside transfers. Expected pbus contents and expected responses are queued
//   when stimulus is issued. They are compared as the DUT produces them.
module tb_pbus_arbiter;

    localparam int NR = 2;
    localparam int TO = 8;
    localparam int EW = NR + 33;   // {onehot, rdata, err}
    localparam int BW = 69;        // {addr, wdata, wstrb, we}

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*32-1:0]  req_addr;
    logic [NR*32-1:0]  req_wdata;
    logic [NR*4-1:0]   req_wstrb;
    logic [NR-1:0]     req_we;
    logic [NR-1:0]     rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [31:0]       pbus_addr;
    logic [31:0]       pbus_wdata;
    logic [3:0]        pbus_wstrb;
    logic              pbus_valid;
    logic              pbus_we;
    logic [31:0]       pbus_rdata;
    logic              pbus_ready;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rsp_cnt  = 0;
    int ws       = 0;
    int busy_cnt = 0;
    int last_busy_len = 0;

    logic [EW-1:0] exp_q[$];
    logic [BW-1:0] bus_q[$];
    int            rsp_cyc_q[$];

    pbus_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .req_we_i     (req_we),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .pbus_addr_o  (pbus_addr),
        .pbus_wdata_o (pbus_wdata),
        .pbus_wstrb_o (pbus_wstrb),
        .pbus_valid_o (pbus_valid),
        .pbus_we_o    (pbus_we),
        .pbus_rdata_i (pbus_rdata),
        .pbus_ready_i (pbus_ready)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (a == 32'h2000_0004) return 32'h1234_5678;
        return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic we);
        req_addr[idx*32 +: 32] = a;
        req_wdata[idx*32 +: 32] = wd;
        req_wstrb[idx*4 +: 4]  = st;
        req_we[idx]            = we;
        req_valid[idx]         = 1'b1;
    endtask

    task automatic expect_txn(input int idx, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input logic we, input logic err);
        logic [NR-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        bus_q.push_back({a, wd, (we ? st : 4'b0000), we});
        exp_q.push_back({oh, (err ? 32'h0 : rdata_of(a)), err});
    endtask

    task automatic wait_rsps(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (rsp_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 72'(rsp_cnt >= target), 72'(1));
    endtask

    // ---------------- peripheral model ----------------
    initial begin
        pbus_ready = 1'b0;
        pbus_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (pbus_valid === 1'b1) begin
                busy_cnt++;
                if (bus_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL bus_unexpected observed=active expected=idle");
                end else begin
                    chk("bus_fields", {pbus_addr, pbus_wdata, pbus_wstrb, pbus_we}, 72'(bus_q[0]));
                end
                if (busy_cnt > ws) begin
                    pbus_ready = 1'b1;
                    pbus_rdata = rdata_of(pbus_addr);
                end else begin
                    pbus_ready = 1'b0;
                    pbus_rdata = $urandom;
                end
            end else begin
                if (busy_cnt > 0) begin
                    last_busy_len = busy_cnt;
                    if (bus_q.size() > 0) void'(bus_q.pop_front());
                end
                busy_cnt   = 0;
                // Ready outside a transfer must have no effect.
                pbus_ready = 1'($urandom_range(0, 1));
                pbus_rdata = $urandom;
            end
        end
    end

    // ---------------- response scoreboard ----------------
    initial forever begin
        logic [EW-1:0] e;
        @(negedge clk);
        if ((|rsp_valid) === 1'b1) begin
            rsp_cnt++;
            rsp_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL rsp_unexpected observed=%0h expected=none", rsp_valid);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_grant", 72'(rsp_valid), 72'(e[EW-1:33]));
                chk("rsp_rdata", 72'(rsp_rdata), 72'(e[32:1]));
                chk("rsp_err", 72'(rsp_err), 72'(e[0]));
                chk("rsp_pbus_idle", 72'(pbus_valid), 72'(0));
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int c0;
        int n0;
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        req_we    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pbus_valid", 72'(pbus_valid), 72'(0));
        chk("rst_rsp_valid", 72'(rsp_valid), 72'(0));
        chk("rst_rsp_err", 72'(rsp_err), 72'(0));
        chk("rst_rsp_rdata", 72'(rsp_rdata), 72'(0));
        chk("rst_pbus_fields", {pbus_addr, pbus_wdata, pbus_wstrb, pbus_we}, 72'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Both requesters held for four zero-wait transactions: 0,1,0,1.
        ws = 0;
        rsp_cyc_q.delete();
        c0 = cyc;
        n0 = rsp_cnt;
        issue(0, 32'h2000_0100, 32'h0, 4'hF, 1'b0);
        issue(1, 32'h2000_0200, 32'h0, 4'hF, 1'b0);
        expect_txn(0, 32'h2000_0100, 32'h0, 4'hF, 1'b0, 1'b0);
        expect_txn(1, 32'h2000_0200, 32'h0, 4'hF, 1'b0, 1'b0);
        expect_txn(0, 32'h2000_0100, 32'h0, 4'hF, 1'b0, 1'b0);
        expect_txn(1, 32'h2000_0200, 32'h0, 4'hF, 1'b0, 1'b0);
        wait_rsps(n0 + 4, 40, "rr_wait");
        req_valid = '0;
        for (int i = 0; i < 4; i++) chk("rr_rsp_cycle", 72'(rsp_cyc_q[i]), 72'(c0 + 2 + 3 * i));

        // Single zero-wait read from requester 0.
        @(posedge clk);
        #1;
        rsp_cyc_q.delete();
        c0 = cyc;
        n0 = rsp_cnt;
        issue(0, 32'h2000_0004, 32'h0, 4'h0, 1'b0);
        expect_txn(0, 32'h2000_0004, 32'h0, 4'h0, 1'b0, 1'b0);
        wait_rsps(n0 + 1, 20, "rd_wait");
        req_valid = '0;
        chk("rd_rsp_cycle", 72'(rsp_cyc_q[0]), 72'(c0 + 2));
        chk("rd_busy_len", 72'(last_busy_len), 72'(1));

        // Requester 1 write, then a read presented with all strobes set.
        @(posedge clk);
        #1;
        n0 = rsp_cnt;
        issue(1, 32'h2000_0010, 32'hA5A5_A5A5, 4'b0011, 1'b1);
        expect_txn(1, 32'h2000_0010, 32'hA5A5_A5A5, 4'b0011, 1'b1, 1'b0);
        wait_rsps(n0 + 1, 20, "wr_wait");
        issue(1, 32'h2000_0014, 32'h5A5A_0000, 4'b1111, 1'b0);
        expect_txn(1, 32'h2000_0014, 32'h5A5A_0000, 4'b1111, 1'b0, 1'b0);
        wait_rsps(n0 + 2, 20, "rdstrb_wait");
        req_valid = '0;

        // Three wait states; requester address changes mid-transfer.
        @(posedge clk);
        #1;
        ws = 3;
        rsp_cyc_q.delete();
        c0 = cyc;
        n0 = rsp_cnt;
        issue(0, 32'h2000_0020, 32'h0, 4'h0, 1'b0);
        expect_txn(0, 32'h2000_0020, 32'h0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        req_addr[31:0] = 32'h2000_0FFC;
        wait_rsps(n0 + 1, 20, "ws3_wait");
        req_valid = '0;
        chk("ws3_rsp_cycle", 72'(rsp_cyc_q[0]), 72'(c0 + 5));
        chk("ws3_busy_len", 72'(last_busy_len), 72'(4));

`ifdef PBUS_ARB_TIMEOUT_EN
        // Ready never arrives: watchdog ends the transfer after TO cycles.
        @(posedge clk);
        #1;
        ws = 1000;
        rsp_cyc_q.delete();
        c0 = cyc;
        n0 = rsp_cnt;
        issue(0, 32'h2000_0030, 32'h0, 4'h0, 1'b0);
        expect_txn(0, 32'h2000_0030, 32'h0, 4'h0, 1'b0, 1'b1);
        wait_rsps(n0 + 1, 40, "to_wait");
        req_valid = '0;
        chk("to_rsp_cycle", 72'(rsp_cyc_q[0]), 72'(c0 + TO + 1));
        chk("to_busy_len", 72'(last_busy_len), 72'(TO));
        ws = 0;
        n0 = rsp_cnt;
        issue(1, 32'h2000_0034, 32'h0, 4'h0, 1'b0);
        expect_txn(1, 32'h2000_0034, 32'h0, 4'h0, 1'b0, 1'b0);
        wait_rsps(n0 + 1, 20, "post_to_wait");
        req_valid = '0;
`else
        // Long stall: without the watchdog the transfer just waits for ready.
        @(posedge clk);
        #1;
        ws = 20;
        rsp_cyc_q.delete();
        c0 = cyc;
        n0 = rsp_cnt;
        issue(0, 32'h2000_0030, 32'h0, 4'h0, 1'b0);
        expect_txn(0, 32'h2000_0030, 32'h0, 4'h0, 1'b0, 1'b0);
        wait_rsps(n0 + 1, 60, "long_wait");
        req_valid = '0;
        chk("long_rsp_cycle", 72'(rsp_cyc_q[0]), 72'(c0 + 22));
        chk("long_busy_len", 72'(last_busy_len), 72'(21));
`endif

        // Reset during BUSY: transfer aborted, no response, pointer to 0.
        @(posedge clk);
        #1;
        ws = 5;
        n0 = rsp_cnt;
        issue(0, 32'h2000_0040, 32'h0, 4'h0, 1'b0);
        bus_q.push_back({32'h2000_0040, 32'h0, 4'b0000, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstb_pbus_valid", 72'(pbus_valid), 72'(0));
        chk("rstb_rsp_valid", 72'(rsp_valid), 72'(0));
        repeat (8) @(posedge clk);
        #1;
        chk("rstb_no_rsp", 72'(rsp_cnt), 72'(n0));
        ws = 0;
        issue(0, 32'h2000_0050, 32'h0, 4'h0, 1'b0);
        issue(1, 32'h2000_0060, 32'h1111_2222, 4'b1100, 1'b1);
        expect_txn(0, 32'h2000_0050, 32'h0, 4'h0, 1'b0, 1'b0);
        expect_txn(1, 32'h2000_0060, 32'h1111_2222, 4'b1100, 1'b1, 1'b0);
        wait_rsps(n0 + 2, 30, "rstb_wait");
        req_valid = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_rsp_drain", 72'(exp_q.size()), 72'(0));
        chk("sb_bus_drain", 72'(bus_q.size()), 72'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
